// File: rtl/helm_usr_mem_arb.sv
// Round-robin arbiter for the shared user-memory register bus.
// Two requesters (helm rx = A, helm tx = B), one transaction at a time.
module helm_usr_mem_arb #(
  parameter int PAGE_W = 8,
  parameter int OFF_W  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [CNT_W-1:0]  ack_timeout_lim,
  input  logic              a_req,
  input  logic              a_wr_en,
  input  logic [PAGE_W-1:0] a_page,
  input  logic [OFF_W-1:0]  a_offset,
  input  logic [DATA_W-1:0] a_wr_data,
  output logic              a_done,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rd_data,
  input  logic              b_req,
  input  logic              b_wr_en,
  input  logic [PAGE_W-1:0] b_page,
  input  logic [OFF_W-1:0]  b_offset,
  input  logic [DATA_W-1:0] b_wr_data,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rd_data,
  output logic              usr_mem_cs,
  output logic              usr_mem_rd_en,
  output logic              usr_mem_wr_en,
  output logic [PAGE_W-1:0] usr_mem_page,
  output logic [OFF_W-1:0]  usr_mem_offset,
  output logic [DATA_W-1:0] usr_mem_wr_data,
  input  logic [DATA_W-1:0] usr_mem_rd_data,
  input  logic              usr_mem_ack,
  output logic [15:0]       timeout_cnt,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [1:0]       state;
  logic             gnt_b;
  logic             last_b;
  logic [CNT_W-1:0] cnt;
  logic             pick_b;
  logic             lim_on;
  logic             tmo;

  // B wins only if A is idle or A was the last one served
  assign pick_b = b_req & (~a_req | ~last_b);
  assign lim_on = (ack_timeout_lim != '0);
  assign tmo    = lim_on & ~usr_mem_ack &
                  (cnt == ack_timeout_lim - ONE);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state           <= IDLE;
      gnt_b           <= 1'b0;
      last_b          <= 1'b1;
      cnt             <= '0;
      a_done          <= 1'b0;
      a_err           <= 1'b0;
      a_rd_data       <= '0;
      b_done          <= 1'b0;
      b_err           <= 1'b0;
      b_rd_data       <= '0;
      usr_mem_cs      <= 1'b0;
      usr_mem_rd_en   <= 1'b0;
      usr_mem_wr_en   <= 1'b0;
      usr_mem_page    <= '0;
      usr_mem_offset  <= '0;
      usr_mem_wr_data <= '0;
      timeout_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            gnt_b      <= pick_b;
            usr_mem_cs <= 1'b1;
            cnt        <= '0;
            state      <= ACCESS;
            if (pick_b) begin
              usr_mem_wr_en   <= b_wr_en;
              usr_mem_rd_en   <= ~b_wr_en;
              usr_mem_page    <= b_page;
              usr_mem_offset  <= b_offset;
              usr_mem_wr_data <= b_wr_data;
            end else begin
              usr_mem_wr_en   <= a_wr_en;
              usr_mem_rd_en   <= ~a_wr_en;
              usr_mem_page    <= a_page;
              usr_mem_offset  <= a_offset;
              usr_mem_wr_data <= a_wr_data;
            end
          end
        end
        ACCESS: begin
          if (usr_mem_ack | tmo) begin
            usr_mem_cs    <= 1'b0;
            usr_mem_rd_en <= 1'b0;
            usr_mem_wr_en <= 1'b0;
            a_done        <= ~gnt_b;
            b_done        <= gnt_b;
            a_err         <= tmo & ~gnt_b;
            b_err         <= tmo & gnt_b;
            state         <= RELEASE;
            if (usr_mem_ack && !usr_mem_wr_en) begin
              if (gnt_b) b_rd_data <= usr_mem_rd_data;
              else       a_rd_data <= usr_mem_rd_data;
            end
            if (tmo && timeout_cnt != 16'hFFFF)
              timeout_cnt <= timeout_cnt + 16'd1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RELEASE: begin
          a_done <= 1'b0;
          a_err  <= 1'b0;
          b_done <= 1'b0;
          b_err  <= 1'b0;
          last_b <= gnt_b;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
